uart_frame_loader: RTL and testbench
====================================

# uart_frame_loader

Upstream feeder for `led_panel_single`. It receives the serial pixel stream on `uart_data`, deframes it as 8N1 UART, and parses the bytes into a sync-delimited frame. It then issues single-cycle writes into the panel framebuffer: one 6-bit word per column per row-pair. The panel scan logic reads that framebuffer independently; this block only writes.

## Interface
- `CLOCK_RATE`, 1000: clk frequency in Hz.
- `BAUD_RATE`, 100: serial bit rate. `CLKS_PER_BIT = CLOCK_RATE/BAUD_RATE` must be ≥ 4 (elaboration error otherwise).
- `clk` in 1: single clock domain.
- `reset` in 1: synchronous, active-high.
- `uart_data` in 1: asynchronous serial line, idle high.
- `fb_we` out 1: framebuffer write strobe, one cycle per pixel word.
- `fb_addr` out 7: write address = row_pair*32 + column, 0..127.
- `fb_data` out 6: {lower-half RGB[2:0], upper-half RGB[2:0]}.
- `frame_done` out 1: one-cycle pulse, coincident with the write to address 127.
- `rx_error` out 1: one-cycle pulse on a framing error or protocol error.

## Operation
- Reset: all outputs 0, RX state IDLE, parser state HUNT, address counter 0, synchroniser flops set to 1.
- Input path: 2-flop synchroniser on `uart_data`. All RX logic uses the second flop (`rx_s`).

RX FSM (IDLE, START, DATA, STOP, WAIT_IDLE):
- IDLE: `rx_s`=0 → START, bit counter cleared.
- START: sample at `CLKS_PER_BIT/2` (integer divide). If 0 → DATA; if 1 → IDLE (glitch rejected, no error).
- DATA: 8 samples spaced `CLKS_PER_BIT` apart, LSB first → STOP.
- STOP: sample after a further `CLKS_PER_BIT`.
  - 1 → byte_valid for one cycle, then IDLE.
  - 0 → `rx_error` pulse, byte discarded, go to WAIT_IDLE.
- WAIT_IDLE: remain until `rx_s`=1, then IDLE.

Parser FSM (HUNT, LOAD), acting on byte_valid:
- HUNT: byte 0xA5 → LOAD with addr=0. All other bytes are ignored silently.
- LOAD, byte[7:6]=00:
  - write `fb_data`=byte[5:0] at addr.
  - if addr=127: pulse `frame_done`, set addr=0, go to HUNT.
  - otherwise addr+1.
- LOAD, byte 0xA5: restart, addr=0, no write, no error.
- LOAD, any other byte: `rx_error` pulse, go to HUNT, addr=0.
- A framing error while in LOAD aborts to HUNT with addr=0. Only one `rx_error` pulse is emitted for it.
- Addresses already written in an aborted frame keep their data. No rollback.
- `fb_addr`/`fb_data` hold their last values between writes. They are valid only when `fb_we`=1.

## Timing
- The stop-bit sample is taken at cycle S. byte_valid is internal at S+1. `fb_we`, `fb_addr`, `fb_data` and `frame_done` are registered and valid at S+2.
- From the first cycle `rx_s`=0, the stop sample S falls `CLKS_PER_BIT/2 + 9*CLKS_PER_BIT` cycles later.
- `rx_error` for a framing error asserts at S+1. For a protocol error it asserts at S+2, aligned with where `fb_we` would have been.
- Back-to-back bytes need no idle gap. RX returns to IDLE at S+1 and can detect the next start edge in the same cycle.
- Throughput is at most one write per `10*CLKS_PER_BIT` cycles.
- `reset` asserted mid-byte or mid-frame takes effect on the next edge. Any partial byte is lost and no write is emitted.

## Structure
- Package `led_panel_pkg` holds:
  - `SYNC_BYTE`=8'hA5
  - `PANEL_COLS`=32
  - `ROW_PAIRS`=4
  - `FB_DEPTH`=128
  - `FB_AW`=7
  - `FB_DW`=6
  - the RX and parser state enums
- Sub-module `uart_rx_8n1` contains the synchroniser, baud counter and RX FSM. It outputs `rx_byte[7:0]`, `byte_valid` and `frame_err`.
- The parser, address counter and output registers stay in the top-level module.

## Test plan
- Send 0xA5 followed by 128 bytes 0x00..0x3F repeating → 128 `fb_we` pulses, addr 0..127, data = byte[5:0]. `frame_done` fires together with the addr-127 write. Parser returns to HUNT.
- Send 0x3F, 0x12 before any sync → no `fb_we`, no `rx_error`. A following 0xA5 then 0x05 → write addr 0, data 0x05.
- Send 0xA5, 10 pixels, 0xA5, 0x21 → writes at addr 0..9, then 0x21 written at addr 0.
- Send 0xA5, 3 pixels, then 0x80 → `rx_error` pulse at S+2, no write, parser in HUNT.
- Drive the stop bit low after 0xA5, 0x01 → `rx_error` at S+1, no write. Line returned high, then 0xA5, 0x07 → write addr 0, data 0x07.
- Pulse `uart_data` low for `CLKS_PER_BIT/2-1` cycles → no byte, no error. Assert `reset` mid-frame (addr 50) → outputs 0, next frame starts at addr 0 only after 0xA5.

Source files
------------

// File: rtl/led_panel_pkg.sv
// Shared constants and state encodings for the LED panel framebuffer loader.
package led_panel_pkg;

    localparam logic [7:0] SYNC_BYTE  = 8'hA5;
    localparam int         PANEL_COLS = 32;
    localparam int         ROW_PAIRS  = 4;
    localparam int         FB_DEPTH   = 128;
    localparam int         FB_AW      = 7;
    localparam int         FB_DW      = 6;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_IDLE
    } rx_state_e;

    typedef enum logic {
        P_HUNT,
        P_LOAD
    } parser_state_e;

endpackage

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: 2-flop synchroniser, baud counter and deframing FSM.
// Emits one byte_valid pulse per good byte, or one frame_err pulse on a bad stop bit.
module uart_rx_8n1
    import led_panel_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t HALF_LAST = cnt_t'(CLKS_PER_BIT / 2 - 1);
    localparam cnt_t FULL_LAST = cnt_t'(CLKS_PER_BIT - 1);

    logic       sync1_q, rx_s_q;
    rx_state_e  state_q, state_d;
    cnt_t       cnt_q, cnt_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] shift_q, shift_d;
    logic       byte_valid_q, byte_valid_d;
    logic       frame_err_q, frame_err_d;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q      <= 1'b1;
            rx_s_q       <= 1'b1;
            state_q      <= RX_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            sync1_q      <= uart_data;
            rx_s_q       <= sync1_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // NOTE: the shift register is pure datapath, only looked at while byte_valid is high, so it carries no reset.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + cnt_t'(1);
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) begin
                    state_d   = RX_START;
                    bit_idx_d = '0;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = rx_s_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        byte_valid_d = 1'b1;
                        state_d      = RX_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = RX_WAIT_IDLE;
                    end
                end
            end
            RX_WAIT_IDLE: begin
                cnt_d = '0;
                if (rx_s_q) state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign rx_byte    = shift_q;
    assign byte_valid = byte_valid_q;
    assign frame_err  = frame_err_q;

endmodule

// File: rtl/uart_frame_loader.sv
// Deframes a sync-delimited UART pixel stream and writes one 6-bit word per
// column per row-pair into the panel framebuffer.
module uart_frame_loader
    import led_panel_pkg::*;
#(
    parameter int CLOCK_RATE = 1000,
    parameter int BAUD_RATE  = 100
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             uart_data,
    output logic             fb_we,
    output logic [FB_AW-1:0] fb_addr,
    output logic [FB_DW-1:0] fb_data,
    output logic             frame_done,
    output logic             rx_error
);

    localparam int CLKS_PER_BIT = CLOCK_RATE / BAUD_RATE;
    localparam logic [FB_AW-1:0] LAST_ADDR = FB_AW'(FB_DEPTH - 1);

    if (CLKS_PER_BIT < 4) begin : g_cfg_check
        $error("uart_frame_loader: CLKS_PER_BIT must be at least 4");
    end

    logic [7:0] rx_byte;
    logic       byte_valid;
    logic       frame_err;

    uart_rx_8n1 #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk        (clk),
        .reset      (reset),
        .uart_data  (uart_data),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    parser_state_e    pstate_q, pstate_d;
    logic [FB_AW-1:0] addr_q, addr_d;
    logic             fb_we_q, fb_we_d;
    logic [FB_AW-1:0] fb_addr_q, fb_addr_d;
    logic [FB_DW-1:0] fb_data_q, fb_data_d;
    logic             frame_done_q, frame_done_d;
    logic             proto_err_q, proto_err_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            pstate_q     <= P_HUNT;
            addr_q       <= '0;
            fb_we_q      <= 1'b0;
            fb_addr_q    <= '0;
            fb_data_q    <= '0;
            frame_done_q <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            pstate_q     <= pstate_d;
            addr_q       <= addr_d;
            fb_we_q      <= fb_we_d;
            fb_addr_q    <= fb_addr_d;
            fb_data_q    <= fb_data_d;
            frame_done_q <= frame_done_d;
            proto_err_q  <= proto_err_d;
        end
    end

    always_comb begin
        pstate_d     = pstate_q;
        addr_d       = addr_q;
        fb_we_d      = 1'b0;
        fb_addr_d    = fb_addr_q;
        fb_data_d    = fb_data_q;
        frame_done_d = 1'b0;
        proto_err_d  = 1'b0;
        // A framing error already pulses rx_error from the receiver; here it only aborts the frame.
        if (frame_err) begin
            pstate_d = P_HUNT;
            addr_d   = '0;
        end else if (byte_valid) begin
            unique case (pstate_q)
                P_HUNT: begin
                    if (rx_byte == SYNC_BYTE) begin
                        pstate_d = P_LOAD;
                        addr_d   = '0;
                    end
                end
                P_LOAD: begin
                    if (rx_byte[7:6] == 2'b00) begin
                        fb_we_d   = 1'b1;
                        fb_addr_d = addr_q;
                        fb_data_d = rx_byte[FB_DW-1:0];
                        if (addr_q == LAST_ADDR) begin
                            frame_done_d = 1'b1;
                            addr_d       = '0;
                            pstate_d     = P_HUNT;
                        end else begin
                            addr_d = addr_q + 1'b1;
                        end
                    end else if (rx_byte == SYNC_BYTE) begin
                        addr_d = '0;
                    end else begin
                        proto_err_d = 1'b1;
                        pstate_d    = P_HUNT;
                        addr_d      = '0;
                    end
                end
                default: pstate_d = P_HUNT;
            endcase
        end
    end

    assign fb_we      = fb_we_q;
    assign fb_addr    = fb_addr_q;
    assign fb_data    = fb_data_q;
    assign frame_done = frame_done_q;
    assign rx_error   = frame_err | proto_err_q;

endmodule

// File: tb/tb_uart_frame_loader.sv
// Scoreboarded bench for uart_frame_loader: serial stimulus with expected
// writes and error pulses queued at drive time and matched cycle-exactly.
module tb_uart_frame_loader;
    import led_panel_pkg::*;

    localparam int CPB      = 10;
    localparam int STOP_OFS = 2 + CPB / 2 + 9 * CPB;

    typedef enum int {EXP_NONE, EXP_WRITE, EXP_FERR, EXP_PERR} exp_e;

    typedef struct {
        logic [FB_AW-1:0] addr;
        logic [FB_DW-1:0] data;
        logic             done;
        int               cyc;
    } exp_wr_t;

    logic             clk;
    logic             reset;
    logic             uart_data;
    logic             fb_we;
    logic [FB_AW-1:0] fb_addr;
    logic [FB_DW-1:0] fb_data;
    logic             frame_done;
    logic             rx_error;

    int      cyc;
    int      checks;
    int      errors;
    exp_wr_t wr_q[$];
    int      err_q[$];

    uart_frame_loader #(
        .CLOCK_RATE (1000),
        .BAUD_RATE  (100)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .uart_data  (uart_data),
        .fb_we      (fb_we),
        .fb_addr    (fb_addr),
        .fb_data    (fb_data),
        .frame_done (frame_done),
        .rx_error   (rx_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic run_monitor();
        exp_wr_t e;
        int      ec;
        forever begin
            @(negedge clk);
            if (fb_we !== 1'b0) begin
                checks++;
                if (wr_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: got addr=%0d data=0x%0h done=%b at cycle %0d, expected no write",
                             fb_addr, fb_data, frame_done, cyc);
                end else begin
                    e = wr_q.pop_front();
                    if (fb_addr !== e.addr || fb_data !== e.data || frame_done !== e.done || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL write: got addr=%0d data=0x%0h done=%b cycle=%0d, expected addr=%0d data=0x%0h done=%b cycle=%0d",
                                 fb_addr, fb_data, frame_done, cyc, e.addr, e.data, e.done, e.cyc);
                    end
                end
            end else if (frame_done !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL frame_done_alone: got frame_done=%b without fb_we at cycle %0d, expected 0", frame_done, cyc);
            end
            if (rx_error !== 1'b0) begin
                checks++;
                if (err_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rx_error: got rx_error=%b at cycle %0d, expected 0", rx_error, cyc);
                end else begin
                    ec = err_q.pop_front();
                    if (cyc != ec) begin
                        errors++;
                        $display("FAIL rx_error_timing: got pulse at cycle %0d, expected cycle %0d", cyc, ec);
                    end
                end
            end
        end
    endtask

    task automatic drive_bit(input logic v);
        uart_data = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    // Queue what this byte must produce, then shift it out LSB first.
    task automatic tx(input logic [7:0] b, input logic stop_val, input exp_e kind,
                      input int addr, input logic done);
        int      s;
        exp_wr_t w;
        s = cyc;
        case (kind)
            EXP_WRITE: begin
                w.addr = FB_AW'(addr);
                w.data = b[5:0];
                w.done = done;
                w.cyc  = s + STOP_OFS + 2;
                wr_q.push_back(w);
            end
            EXP_FERR: err_q.push_back(s + STOP_OFS + 1);
            EXP_PERR: err_q.push_back(s + STOP_OFS + 2);
            default: ;
        endcase
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_val);
        if (!stop_val) begin
            drive_bit(1'b1);
            drive_bit(1'b1);
        end
    endtask

    task automatic check_drained(input string name);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (wr_q.size() != 0 || err_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drained: got %0d writes and %0d rx_error pulses still outstanding, expected 0 and 0",
                     name, wr_q.size(), err_q.size());
            wr_q.delete();
            err_q.delete();
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        uart_data = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({fb_we, fb_addr, fb_data, frame_done, rx_error} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got we=%b addr=%0d data=0x%0h done=%b err=%b, expected all 0",
                     fb_we, fb_addr, fb_data, frame_done, rx_error);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2 * CPB) @(posedge clk);
        #1;
        checks++;
        if ({fb_we, fb_addr, fb_data, frame_done, rx_error} !== '0) begin
            errors++;
            $display("FAIL post_reset_idle: got we=%b addr=%0d data=0x%0h done=%b err=%b, expected all 0",
                     fb_we, fb_addr, fb_data, frame_done, rx_error);
        end
    endtask

    task automatic test_full_frame();
        tx(SYNC_BYTE, 1'b1, EXP_NONE, 0, 1'b0);
        for (int i = 0; i < FB_DEPTH; i++)
            tx(8'(i % 64), 1'b1, EXP_WRITE, i, (i == FB_DEPTH - 1));
        tx(8'h01, 1'b1, EXP_NONE, 0, 1'b0);
        check_drained("full_frame");
    endtask

    task automatic test_hunt_ignores();
        tx(8'h3F, 1'b1, EXP_NONE, 0, 1'b0);
        tx(8'h12, 1'b1, EXP_NONE, 0, 1'b0);
        tx(SYNC_BYTE, 1'b1, EXP_NONE, 0, 1'b0);
        tx(8'h05, 1'b1, EXP_WRITE, 0, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (fb_we !== 1'b0 || fb_addr !== 7'd0 || fb_data !== 6'h05) begin
            errors++;
            $display("FAIL hold_last_write: got we=%b addr=%0d data=0x%0h, expected we=0 addr=0 data=0x5",
                     fb_we, fb_addr, fb_data);
        end
        check_drained("hunt_ignores");
    endtask

    task automatic test_sync_restart();
        tx(SYNC_BYTE, 1'b1, EXP_NONE, 0, 1'b0);
        for (int i = 0; i < 10; i++) tx(8'(8'h10 + i), 1'b1, EXP_WRITE, i, 1'b0);
        tx(SYNC_BYTE, 1'b1, EXP_NONE, 0, 1'b0);
        tx(8'h21, 1'b1, EXP_WRITE, 0, 1'b0);
        check_drained("sync_restart");
    endtask

    task automatic test_protocol_error();
        tx(SYNC_BYTE, 1'b1, EXP_NONE, 0, 1'b0);
        tx(8'h2A, 1'b1, EXP_WRITE, 0, 1'b0);
        tx(8'h15, 1'b1, EXP_WRITE, 1, 1'b0);
        tx(8'h3C, 1'b1, EXP_WRITE, 2, 1'b0);
        tx(8'h80, 1'b1, EXP_PERR, 0, 1'b0);
        tx(8'h02, 1'b1, EXP_NONE, 0, 1'b0);
        check_drained("protocol_error");
    endtask

    task automatic test_framing_error();
        tx(SYNC_BYTE, 1'b1, EXP_NONE, 0, 1'b0);
        tx(8'h01, 1'b0, EXP_FERR, 0, 1'b0);
        tx(8'h03, 1'b1, EXP_NONE, 0, 1'b0);
        tx(SYNC_BYTE, 1'b1, EXP_NONE, 0, 1'b0);
        tx(8'h07, 1'b1, EXP_WRITE, 0, 1'b0);
        check_drained("framing_error");
    endtask

    task automatic test_glitch();
        uart_data = 1'b0;
        repeat (CPB / 2 - 1) @(posedge clk);
        #1;
        uart_data = 1'b1;
        repeat (3 * CPB) @(posedge clk);
        #1;
        tx(SYNC_BYTE, 1'b1, EXP_NONE, 0, 1'b0);
        tx(8'h33, 1'b1, EXP_WRITE, 0, 1'b0);
        check_drained("glitch");
    endtask

    task automatic test_reset_mid_frame();
        tx(SYNC_BYTE, 1'b1, EXP_NONE, 0, 1'b0);
        for (int i = 0; i < 50; i++) tx(8'(i ^ 8'h2B), 1'b1, EXP_WRITE, i, 1'b0);
        uart_data = 1'b0;
        repeat (3 * CPB) @(posedge clk);
        #1;
        reset     = 1'b1;
        uart_data = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({fb_we, fb_addr, fb_data, frame_done, rx_error} !== '0) begin
            errors++;
            $display("FAIL mid_frame_reset: got we=%b addr=%0d data=0x%0h done=%b err=%b, expected all 0",
                     fb_we, fb_addr, fb_data, frame_done, rx_error);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3 * CPB) @(posedge clk);
        #1;
        tx(8'h09, 1'b1, EXP_NONE, 0, 1'b0);
        tx(SYNC_BYTE, 1'b1, EXP_NONE, 0, 1'b0);
        tx(8'h0B, 1'b1, EXP_WRITE, 0, 1'b0);
        check_drained("reset_mid_frame");
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        uart_data = 1'b1;
        fork
            run_monitor();
        join_none
        @(posedge clk);
        #1;
        test_reset();
        test_full_frame();
        test_hunt_ignores();
        test_sync_restart();
        test_protocol_error();
        test_framing_error();
        test_glitch();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
